// File: rtl/captura_pkg.sv
// Shared definitions for the camera capture path: output format codes, capture FSM encoding
// and the RGB565 -> {RGB332, RGB444, RGB565} pixel packing function.
package captura_pkg;

  localparam int FMT_RGB332 = 0;
  localparam int FMT_RGB444 = 1;
  localparam int FMT_RGB565 = 2;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ARMED     = 2'd1,
    CAPTURE   = 2'd2
  } cap_state_e;

  // b0 is the first camera byte (R + upper G), b1 the second (lower G + B).
  function automatic logic [15:0] pack_pixel(input logic [7:0] b0, input logic [7:0] b1,
                                             input int fmt);
    logic [15:0] pix;
    case (fmt)
      FMT_RGB332: pix = {8'h00, b0[7:5], b0[2:0], b1[4:3]};
      FMT_RGB444: pix = {4'h0, b0[7:4], b0[2:0], b1[7], b1[4:1]};
      default:    pix = {b0, b1};
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Combinational pixel packer: two camera bytes -> 16-bit word in the selected output format.
// Also used by the test-pattern generator, so it stays free of any capture state.
module pixel_packer
  import captura_pkg::*;
#(
  parameter int OUT_FMT = FMT_RGB332
) (
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  output logic [15:0] pix_word
);

  assign pix_word = pack_pixel(b0, b1, OUT_FMT);

endmodule

// File: rtl/captura_de_datos_param.sv
// OV7670 capture stage: frame-sync FSM, byte pairing, bounded DP RAM write addressing.
// Define CAPTURE_DECIM2_EN to store only even pixels of even lines (2x decimation).
module captura_de_datos_param
  import captura_pkg::*;
#(
  parameter int OUT_FMT = FMT_RGB332,
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int ADDR_W  = 15
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  output logic [15:0]       DP_RAM_data_in,
  output logic [ADDR_W-1:0] DP_RAM_addr_in,
  output logic              DP_RAM_regW,
  output logic              frame_done,
  output logic              overflow
);

  // One extra counter bit so the address can sit at IMG_W*IMG_H even when that equals 2^ADDR_W.
  localparam int               CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] PIX_N = CNT_W'(IMG_W * IMG_H);

  cap_state_e       state_q, state_d;
  logic             byte_phase_q;
  logic             href_q;
  logic [7:0]       byte0_q;
  logic [CNT_W-1:0] addr_q;
  logic [15:0]      packed_word;

  logic start_frame, accept, line_end, pixel_done, keep;

  assign start_frame = (state_q == ARMED) && !VSYNC;
  assign accept      = (state_q == CAPTURE) && HREF && !VSYNC;
  assign line_end    = href_q && !accept;
  assign pixel_done  = accept && byte_phase_q;

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      WAIT_SYNC: if (VSYNC)  state_d = ARMED;
      ARMED:     if (!VSYNC) state_d = CAPTURE;
      CAPTURE:   if (VSYNC)  state_d = ARMED;
      default:               state_d = WAIT_SYNC;
    endcase
  end

`ifdef CAPTURE_DECIM2_EN
  logic pix_odd_q, line_odd_q;

  always_ff @(posedge PCLK) begin
    if (RST || start_frame) begin
      pix_odd_q  <= 1'b0;
      line_odd_q <= 1'b0;
    end else if (line_end) begin
      pix_odd_q  <= 1'b0;
      line_odd_q <= ~line_odd_q;
    end else if (pixel_done) begin
      pix_odd_q  <= ~pix_odd_q;
    end
  end

  assign keep = !pix_odd_q && !line_odd_q;
`else
  assign keep = 1'b1;
`endif

  pixel_packer #(.OUT_FMT(OUT_FMT)) u_packer (
    .b0       (byte0_q),
    .b1       (D),
    .pix_word (packed_word)
  );

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge PCLK) begin
    if (RST) begin
      state_q        <= WAIT_SYNC;
      byte_phase_q   <= 1'b0;
      href_q         <= 1'b0;
      byte0_q        <= '0;
      addr_q         <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state_q     <= state_d;
      href_q      <= accept;
      DP_RAM_regW <= 1'b0;
      frame_done  <= (state_q == CAPTURE) && VSYNC;

      if (start_frame || line_end) byte_phase_q <= 1'b0;
      else if (accept)             byte_phase_q <= ~byte_phase_q;

      if (accept && !byte_phase_q) byte0_q <= D;

      if (start_frame) begin
        addr_q   <= '0;
        overflow <= 1'b0;
      end else begin
        // The write address advances once the strobe has been presented with it.
        if (DP_RAM_regW) addr_q <= addr_q + 1'b1;
        if (pixel_done && keep) begin
          if (addr_q == PIX_N) begin
            overflow <= 1'b1;
          end else begin
            DP_RAM_regW    <= 1'b1;
            DP_RAM_data_in <= packed_word;
          end
        end
      end
    end
  end

  assign DP_RAM_addr_in = addr_q[ADDR_W-1:0];

endmodule

// File: tb/tb_captura_de_datos_param.sv
// Scoreboard bench for captura_de_datos_param: four instances (RGB332/444/565 full size and a
// 2x2 RGB565 frame) share one camera stream; expected writes are queued as bytes are driven.
module tb_captura_de_datos_param;

  localparam int NI = 4;

`ifdef CAPTURE_DECIM2_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  logic pclk = 1'b0;
  logic rst, vsync, href;
  logic [7:0] d;

  logic [15:0] data [NI];
  logic [14:0] addr [NI];
  logic        regw [NI];
  logic        fd   [NI];
  logic        ovf  [NI];

  always #5 pclk = ~pclk;

  captura_de_datos_param #(.OUT_FMT(0)) u_rgb332 (
    .PCLK(pclk), .RST(rst), .VSYNC(vsync), .HREF(href), .D(d),
    .DP_RAM_data_in(data[0]), .DP_RAM_addr_in(addr[0]), .DP_RAM_regW(regw[0]),
    .frame_done(fd[0]), .overflow(ovf[0]));

  captura_de_datos_param #(.OUT_FMT(1)) u_rgb444 (
    .PCLK(pclk), .RST(rst), .VSYNC(vsync), .HREF(href), .D(d),
    .DP_RAM_data_in(data[1]), .DP_RAM_addr_in(addr[1]), .DP_RAM_regW(regw[1]),
    .frame_done(fd[1]), .overflow(ovf[1]));

  captura_de_datos_param #(.OUT_FMT(2)) u_rgb565 (
    .PCLK(pclk), .RST(rst), .VSYNC(vsync), .HREF(href), .D(d),
    .DP_RAM_data_in(data[2]), .DP_RAM_addr_in(addr[2]), .DP_RAM_regW(regw[2]),
    .frame_done(fd[2]), .overflow(ovf[2]));

  captura_de_datos_param #(.OUT_FMT(2), .IMG_W(2), .IMG_H(2), .ADDR_W(15)) u_small (
    .PCLK(pclk), .RST(rst), .VSYNC(vsync), .HREF(href), .D(d),
    .DP_RAM_data_in(data[3]), .DP_RAM_addr_in(addr[3]), .DP_RAM_regW(regw[3]),
    .frame_done(fd[3]), .overflow(ovf[3]));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [30:0] exp_q [NI][$];
  int          exp_addr [NI];
  bit          ovf_exp [NI];
  int          fd_cnt [NI];
  bit          capturing = 1'b0;
  bit          phase = 1'b0;
  logic [7:0]  b0_m;
  int          pix = 0;
  int          line = 0;
  logic [30:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int fmt_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 2;
  endfunction

  function automatic int cap_of(input int i);
    return (i == 3) ? 4 : 160 * 120;
  endfunction

  function automatic logic [15:0] model_pix(input int fmt, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    r = '0;
    if (fmt == 0) begin
      r[7:5] = a[7:5];  r[4:2] = a[2:0];  r[1:0] = b[4:3];
    end else if (fmt == 1) begin
      r[11:8] = a[7:4]; r[7:5] = a[2:0]; r[4] = b[7]; r[3:0] = b[4:1];
    end else begin
      r = {a, b};
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic pixel_complete(input logic [7:0] b1);
    bit keep;
    keep = DECIM ? ((pix % 2 == 0) && (line % 2 == 0)) : 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (keep) begin
        if (exp_addr[i] < cap_of(i)) begin
          exp_q[i].push_back({15'(exp_addr[i]), model_pix(fmt_of(i), b0_m, b1)});
          exp_addr[i]++;
        end else begin
          ovf_exp[i] = 1'b1;
        end
      end
    end
    pix++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    vsync = 1'b0;
    href  = 1'b1;
    d     = b;
    if (capturing) begin
      if (!phase) b0_m = b;
      else        pixel_complete(b);
      phase = ~phase;
    end
    cyc();
  endtask

  task automatic end_line();
    href = 1'b0;
    d    = 8'h00;
    if (capturing) begin
      phase = 1'b0;
      pix   = 0;
      line++;
    end
    cyc();
    cyc();
    for (int i = 0; i < NI; i++) check($sformatf("drain%0d", i), exp_q[i].size(), 0);
  endtask

  task automatic frame_start(input bit junk_href);
    int saved [NI];
    for (int i = 0; i < NI; i++) saved[i] = fd_cnt[i];
    vsync = 1'b1;
    href  = junk_href;
    d     = 8'h5A;
    repeat (3) cyc();
    vsync = 1'b0;
    href  = 1'b0;
    cyc();
    capturing = 1'b1;
    phase     = 1'b0;
    pix       = 0;
    line      = 0;
    for (int i = 0; i < NI; i++) begin
      exp_addr[i] = 0;
      ovf_exp[i]  = 1'b0;
      check($sformatf("ovf_clr%0d", i), ovf[i], ovf_exp[i]);
      check($sformatf("fd_quiet%0d", i), fd_cnt[i], saved[i]);
      check($sformatf("addr_restart%0d", i), addr[i], 0);
    end
  endtask

  task automatic frame_end();
    int saved [NI];
    for (int i = 0; i < NI; i++) saved[i] = fd_cnt[i];
    vsync = 1'b1;
    href  = 1'b0;
    repeat (3) cyc();
    capturing = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("fd_pulse%0d", i), fd_cnt[i], saved[i] + 1);
      check($sformatf("ovf%0d", i), ovf[i], ovf_exp[i]);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_data%0d", tag, i), data[i], 0);
      check($sformatf("%s_addr%0d", tag, i), addr[i], 0);
      check($sformatf("%s_regw%0d", tag, i), regw[i], 0);
      check($sformatf("%s_fd%0d", tag, i), fd[i], 0);
      check($sformatf("%s_ovf%0d", tag, i), ovf[i], 0);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write of that instance.
  always @(negedge pclk) begin
    for (int i = 0; i < NI; i++) begin
      if (fd[i]) fd_cnt[i]++;
      if (regw[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("spurious_wr%0d", i), regw[i], 0);
        end else begin
          mon_e = exp_q[i].pop_front();
          check($sformatf("wr_addr%0d", i), addr[i], mon_e[30:16]);
          check($sformatf("wr_data%0d", i), data[i], mon_e[15:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      exp_addr[i] = 0;
      ovf_exp[i]  = 1'b0;
      fd_cnt[i]   = 0;
    end
    rst = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00;
    repeat (3) cyc();
    check_zero("reset");
    rst = 1'b0;
    cyc();

    // Data with no preceding VSYNC high/low must never be written.
    send_byte(8'hE5); send_byte(8'h1C); end_line();

    // HREF high during vertical blanking is ignored.
    frame_start(1'b1);
    send_byte(8'hE5); send_byte(8'h1C); send_byte(8'h00); send_byte(8'hFF); end_line();
    send_byte(8'hF8); send_byte(8'h1F); end_line();
    // Odd trailing byte discarded; next line restarts at byte0.
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); end_line();
    send_byte(8'h9A); send_byte(8'hBC); end_line();
    for (int k = 0; k < 12; k++) send_byte(8'($urandom_range(0, 255)));
    end_line();
    frame_end();

    // 4x2 pixel frame: restart at address 0; the 2x2 instance overflows without decimation.
    frame_start(1'b0);
    repeat (2) begin
      for (int k = 0; k < 8; k++) send_byte(8'($urandom_range(0, 255)));
      end_line();
    end
    frame_end();

    // Reset in the middle of a line.
    frame_start(1'b0);
    for (int k = 0; k < 15; k++) send_byte(8'($urandom_range(0, 255)));
    check("addr_before_rst", addr[0], exp_addr[0]);
    rst = 1'b1;
    d   = 8'h77;
    cyc();
    check_zero("midrst");
    rst       = 1'b0;
    capturing = 1'b0;
    phase     = 1'b0;
    pix       = 0;
    line      = 0;
    for (int i = 0; i < NI; i++) exp_addr[i] = 0;
    end_line();
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F); send_byte(8'hF0); end_line();

    // Capture resumes after a full VSYNC high/low sequence.
    frame_start(1'b0);
    send_byte(8'hC3); send_byte(8'h3C); send_byte(8'h81); send_byte(8'h18); end_line();
    frame_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
